// File: rtl/sd_cmd_tx_if.sv
// Parallel command side and serial CMD pad side of the SD command transmitter.
// The master modport is the requester plus strobe source; the slave modport is sd_cmd_tx.
interface sd_cmd_tx_if;
  localparam int unsigned IndexW = 6;
  localparam int unsigned ArgW   = 32;
  localparam int unsigned CrcW   = 7;

  logic              clk_en_i;
  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic [IndexW-1:0] cmd_index_i;
  logic [ArgW-1:0]   cmd_arg_i;
  logic [CrcW-1:0]   cmd_crc_i;
  logic              cmd_o;
  logic              cmd_oe_o;
  logic              busy_o;
  logic              done_o;

  modport master (
    output clk_en_i, cmd_valid_i, cmd_index_i, cmd_arg_i, cmd_crc_i,
    input  cmd_ready_o, cmd_o, cmd_oe_o, busy_o, done_o
  );

  modport slave (
    input  clk_en_i, cmd_valid_i, cmd_index_i, cmd_arg_i, cmd_crc_i,
    output cmd_ready_o, cmd_o, cmd_oe_o, busy_o, done_o
  );
endinterface

// File: rtl/sd_cmd_tx.sv
// SD CMD-line transmitter: builds the 48-bit command frame and shifts it out MSb first
// on SD clock strobes. Define SDHCI_CMD_TX_CRC7_EN to generate CRC7 internally.
module sd_cmd_tx #(
  parameter int unsigned GapStrobes = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  sd_cmd_tx_if.slave  bus
);
  localparam int unsigned HdrW = 40;
  localparam int unsigned CrcW = 7;
  localparam int unsigned CntW = 8;

  localparam logic [CntW-1:0] HdrLast = CntW'(HdrW - 1);
  localparam logic [CntW-1:0] CrcLast = CntW'(CrcW - 1);
  localparam logic [CntW-1:0] GapLast = CntW'((GapStrobes == 0) ? 0 : GapStrobes - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_CRC,
    ST_END,
    ST_GAP
  } state_e;

  state_e            state_q, state_d;
  logic [HdrW-1:0]   hdr_q, hdr_d;
  logic [CrcW-1:0]   crc_q, crc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              cmd_q, cmd_d;
  logic              oe_q, oe_d;
  logic              done_q, done_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic [CrcW-1:0]   crc_step;

`ifdef SDHCI_CMD_TX_CRC7_EN
  localparam logic [CrcW-1:0] CrcPoly = 7'h09;

  // Serial CRC7 update with the header bit currently on the line.
  always_comb begin
    crc_step = {crc_q[CrcW-2:0], 1'b0};
    if (hdr_q[HdrW-1] ^ crc_q[CrcW-1]) begin
      crc_step = crc_step ^ CrcPoly;
    end
  end

  logic unused_crc_in;
  assign unused_crc_in = ^bus.cmd_crc_i;
`else
  // CRC comes verbatim from the requester; the register only shifts it out.
  assign crc_step = crc_q;

  logic unused_hdr_msb;
  assign unused_hdr_msb = hdr_q[HdrW-1];
`endif

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    crc_d   = crc_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    oe_d    = oe_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cmd_d = 1'b1;
        oe_d  = 1'b0;
        if (bus.cmd_valid_i) begin
          state_d = ST_HEADER;
          hdr_d   = {2'b01, bus.cmd_index_i, bus.cmd_arg_i};
`ifdef SDHCI_CMD_TX_CRC7_EN
          crc_d   = '0;
`else
          crc_d   = bus.cmd_crc_i;
`endif
          cnt_d   = '0;
          cmd_d   = 1'b0;
          oe_d    = 1'b1;
        end
      end

      ST_HEADER: begin
        if (bus.clk_en_i) begin
          hdr_d = {hdr_q[HdrW-2:0], 1'b0};
          crc_d = crc_step;
          if (cnt_q == HdrLast) begin
            state_d = ST_CRC;
            cnt_d   = '0;
            cmd_d   = crc_d[CrcW-1];
          end else begin
            cnt_d = cnt_q + CntW'(1);
            cmd_d = hdr_q[HdrW-2];
          end
        end
      end

      ST_CRC: begin
        if (bus.clk_en_i) begin
          crc_d = {crc_q[CrcW-2:0], 1'b0};
          if (cnt_q == CrcLast) begin
            state_d = ST_END;
            cnt_d   = '0;
            cmd_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
            cmd_d = crc_q[CrcW-2];
          end
        end
      end

      ST_END: begin
        cmd_d = 1'b1;
        if (bus.clk_en_i) begin
          done_d  = 1'b1;
          oe_d    = 1'b0;
          cnt_d   = '0;
          state_d = (GapStrobes == 0) ? ST_IDLE : ST_GAP;
        end
      end

      ST_GAP: begin
        cmd_d = 1'b1;
        oe_d  = 1'b0;
        if (bus.clk_en_i) begin
          if (cnt_q == GapLast) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        cmd_d   = 1'b1;
        oe_d    = 1'b0;
      end
    endcase

    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      hdr_q   <= '0;
      crc_q   <= '0;
      cnt_q   <= '0;
      cmd_q   <= 1'b1;
      oe_q    <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      oe_q    <= oe_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.cmd_o       = cmd_q;
  assign bus.cmd_oe_o    = oe_q;
  assign bus.done_o      = done_q;
  assign bus.cmd_ready_o = ready_q;
  assign bus.busy_o      = busy_q;
endmodule

// File: tb/tb_sd_cmd_tx.sv
// Self-checking bench for sd_cmd_tx: known frames, random commands against a
// polynomial-division CRC model, gap timing, stall, and mid-frame reset.
module tb_sd_cmd_tx;
  logic clk = 1'b0;
  logic rst_n;

  sd_cmd_tx_if b ();
  sd_cmd_tx_if b0 ();

  sd_cmd_tx #(.GapStrobes(8)) dut  (.clk_i(clk), .rst_ni(rst_n), .bus(b));
  sd_cmd_tx #(.GapStrobes(0)) dut0 (.clk_i(clk), .rst_ni(rst_n), .bus(b0));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Remainder of header(x) * x^7 divided by x^7+x^3+1.
  function automatic logic [6:0] crc7_div(input logic [39:0] hdr);
    logic [46:0] v;
    logic [46:0] g;
    v = {hdr, 7'b0};
    for (int k = 46; k >= 7; k--) begin
      if (v[k]) begin
        g = 47'(8'h89);
        v = v ^ (g << (k - 7));
      end
    end
    return v[6:0];
  endfunction

  function automatic logic [6:0] exp_crc(input logic [5:0] idx, input logic [31:0] arg,
                                         input logic [6:0] crc_in);
`ifdef SDHCI_CMD_TX_CRC7_EN
    return crc7_div({2'b01, idx, arg});
`else
    return crc_in;
`endif
  endfunction

  function automatic logic [47:0] frame_of(input logic [5:0] idx, input logic [31:0] arg,
                                           input logic [6:0] crc_in);
    return {2'b01, idx, arg, exp_crc(idx, arg, crc_in), 1'b1};
  endfunction

  // Strobe generator: every en_period cycles, random when 0, frozen while en_hold.
  int en_period = 1;
  bit en_hold = 1'b0;
  int cyc = 0;
  initial begin
    b.clk_en_i  = 1'b0;
    b0.clk_en_i = 1'b0;
    forever begin
      logic e;
      @(posedge clk);
      #1;
      cyc++;
      if (en_hold)             e = 1'b0;
      else if (en_period == 0) e = 1'($urandom_range(0, 1));
      else                     e = ((cyc % en_period) == 0);
      b.clk_en_i  = e;
      b0.clk_en_i = e;
    end
  end

  // Line monitor: collects bits consumed by strobes while the pad is driven.
  int          nbits = 0;
  logic [47:0] shv = '0;
  int          done_cycles = 0;
  int          oe_bad = 0;
  logic [47:0] frames[$];
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        nbits = 0;
        shv   = '0;
      end else begin
        if (b.done_o) done_cycles++;
        if (!b.cmd_oe_o && !b.cmd_o) oe_bad++;
        if (b.cmd_oe_o && b.clk_en_i) begin
          shv = {shv[46:0], b.cmd_o};
          nbits++;
          if (nbits == 48) begin
            frames.push_back(shv);
            nbits = 0;
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [5:0] idx, input logic [31:0] arg, input logic [6:0] crc);
    int t = 0;
    while (!b.cmd_ready_o && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("send_ready", b.cmd_ready_o, 1'b1);
    b.cmd_index_i = idx;
    b.cmd_arg_i   = arg;
    b.cmd_crc_i   = crc;
    b.cmd_valid_i = 1'b1;
    @(posedge clk);
    #1;
    b.cmd_valid_i = 1'b0;
    b.cmd_index_i = 6'($urandom);
    b.cmd_arg_i   = $urandom;
    b.cmd_crc_i   = 7'($urandom);
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while (!b.done_o && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_done"}, b.done_o, 1'b1);
    chk({name, "_oe_fall"}, b.cmd_oe_o, 1'b0);
    chk({name, "_strobes"}, nbits, 0);
  endtask

  task automatic pulse_check(input string name);
    @(negedge clk);
    chk({name, "_pulse"}, b.done_o, 1'b0);
  endtask

  task automatic check_frame(input string name, input logic [47:0] exp);
    logic [47:0] got;
    got = (frames.size() > 0) ? frames.pop_front() : 48'h0;
    chk({name, "_frame"}, got, exp);
  endtask

  task automatic wait_bits(input int n);
    int t = 0;
    while (nbits < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("wait_bits", (nbits >= n), 1'b1);
  endtask

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [6:0]  crc;
    int          per;
    logic [47:0] exp;
  } vec_t;

`ifdef SDHCI_CMD_TX_CRC7_EN
  localparam logic [47:0] Cmd0Crc55Exp = 48'h400000000095;
`else
  localparam logic [47:0] Cmd0Crc55Exp = 48'h4000000000AB;
`endif

  initial begin
    vec_t        vecs[4];
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [6:0]  crc;
    logic        held;
    int          cnt;
    int          t;
    int          dc;

    vecs[0] = '{6'd0,  32'h0000_0000, 7'h4A, 4, 48'h400000000095};
    vecs[1] = '{6'd8,  32'h0000_01AA, 7'h43, 1, 48'h48000001AA87};
    vecs[2] = '{6'd17, 32'h0000_0000, 7'h2A, 2, 48'h510000000055};
    vecs[3] = '{6'd0,  32'h0000_0000, 7'h55, 3, Cmd0Crc55Exp};

    rst_n = 1'b0;
    b.cmd_valid_i  = 1'b0; b.cmd_index_i  = '0; b.cmd_arg_i  = '0; b.cmd_crc_i  = '0;
    b0.cmd_valid_i = 1'b0; b0.cmd_index_i = '0; b0.cmd_arg_i = '0; b0.cmd_crc_i = '0;

    repeat (2) @(negedge clk);
    chk("rst_cmd", b.cmd_o, 1'b1);
    chk("rst_oe", b.cmd_oe_o, 1'b0);
    chk("rst_ready", b.cmd_ready_o, 1'b1);
    chk("rst_busy", b.busy_o, 1'b0);
    chk("rst_done", b.done_o, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Known frames from the SD spec examples.
    for (int i = 0; i < 4; i++) begin
      en_period = vecs[i].per;
      send(vecs[i].idx, vecs[i].arg, vecs[i].crc);
      chk("start_bit", b.cmd_o, 1'b0);
      chk("start_oe", b.cmd_oe_o, 1'b1);
      chk("start_busy", b.busy_o, 1'b1);
      wait_done($sformatf("vec%0d", i));
      check_frame($sformatf("vec%0d", i), vecs[i].exp);
      pulse_check($sformatf("vec%0d", i));
    end

    // Random commands and strobe patterns.
    for (int i = 0; i < 16; i++) begin
      idx = 6'($urandom);
      arg = $urandom;
      crc = 7'($urandom);
      en_period = $urandom_range(0, 4);
      send(idx, arg, crc);
      wait_done($sformatf("rnd%0d", i));
      check_frame($sformatf("rnd%0d", i), frame_of(idx, arg, crc));
      pulse_check($sformatf("rnd%0d", i));
    end

    // Back-to-back with valid held: 8 gap strobes before the next start bit.
    en_period = 3;
    t = 0;
    while (!b.cmd_ready_o && t < 3000) begin @(negedge clk); t++; end
    idx = 6'd55; arg = 32'hDEAD_BEEF; crc = 7'h11;
    b.cmd_index_i = idx; b.cmd_arg_i = arg; b.cmd_crc_i = crc;
    b.cmd_valid_i = 1'b1;
    wait_done("gap_first");
    cnt = 0;
    t = 0;
    while (!b.cmd_ready_o && t < 500) begin
      if (b.clk_en_i) cnt++;
      @(negedge clk);
      t++;
    end
    chk("gap_strobes", cnt, 8);
    @(negedge clk);
    chk("gap_start_oe", b.cmd_oe_o, 1'b1);
    chk("gap_start_bit", b.cmd_o, 1'b0);
    b.cmd_valid_i = 1'b0;
    wait_done("gap_second");
    check_frame("gap_first", frame_of(idx, arg, crc));
    check_frame("gap_second", frame_of(idx, arg, crc));
    pulse_check("gap_second");

    // Zero gap: ready in the done cycle, start bit right after.
    en_period = 2;
    b0.cmd_index_i = 6'd8; b0.cmd_arg_i = 32'h1AA; b0.cmd_crc_i = 7'h43;
    b0.cmd_valid_i = 1'b1;
    t = 0;
    while (!b0.done_o && t < 3000) begin @(negedge clk); t++; end
    chk("gap0_done", b0.done_o, 1'b1);
    chk("gap0_ready", b0.cmd_ready_o, 1'b1);
    @(negedge clk);
    chk("gap0_start_oe", b0.cmd_oe_o, 1'b1);
    chk("gap0_start_bit", b0.cmd_o, 1'b0);
    b0.cmd_valid_i = 1'b0;
    t = 0;
    while (!b0.done_o && t < 3000) begin @(negedge clk); t++; end
    chk("gap0_second_done", b0.done_o, 1'b1);

    // Stalled strobe mid-header with inputs changing underneath.
    en_period = 1;
    idx = 6'd17; arg = 32'h0; crc = 7'h2A;
    send(idx, arg, crc);
    wait_bits(10);
    en_hold = 1'b1;
    repeat (2) @(negedge clk);
    held = b.cmd_o;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("stall_hold", b.cmd_o, held);
      chk("stall_ready", b.cmd_ready_o, 1'b0);
      b.cmd_index_i = 6'($urandom);
      b.cmd_arg_i   = $urandom;
      b.cmd_valid_i = 1'($urandom_range(0, 1));
    end
    b.cmd_valid_i = 1'b0;
    en_hold = 1'b0;
    wait_done("stall");
    check_frame("stall", frame_of(idx, arg, crc));
    pulse_check("stall");

    // Asynchronous reset at bit 20, then a clean command.
    en_period = 2;
    send(6'd41, 32'h4030_0000, 7'h3C);
    wait_bits(20);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_oe", b.cmd_oe_o, 1'b0);
    chk("mrst_cmd", b.cmd_o, 1'b1);
    chk("mrst_ready", b.cmd_ready_o, 1'b1);
    chk("mrst_busy", b.busy_o, 1'b0);
    chk("mrst_done", b.done_o, 1'b0);
    dc = done_cycles;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    frames.delete();
    repeat (120) @(negedge clk);
    chk("mrst_no_done", done_cycles, dc);
    chk("mrst_no_frame", frames.size(), 0);
    send(6'd8, 32'h1AA, 7'h43);
    wait_done("post_rst");
    check_frame("post_rst", 48'h48000001AA87);
    pulse_check("post_rst");

    chk("idle_line_high", oe_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sd_cmd_tx.md
# sd_cmd_tx

SD command-line transmitter for the SDHCI host: accepts a command (index + argument), builds the 48-bit SD command frame, and shifts it out MSb first on the CMD line, one bit per SD clock strobe. It is the transmit counterpart of the CMD-line serial-to-parallel response receiver. It sits between the SDHCI command FSM (parallel side) and the CMD pad driver (serial side, with output enable).

## Interface

**Parameters**
- `GapStrobes`, default 8: minimum number of `clk_en_i` strobes after the end bit before the next command may start (SD N_CC). Legal range 0..255.

**Ports**
- `clk_i` in 1: system clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `clk_en_i` in 1: SD clock strobe. All bit advances happen only on edges where this is 1.
- `cmd_valid_i` in 1: command request.
- `cmd_ready_o` out 1: transmitter can accept a command.
- `cmd_index_i` in 6: command index.
- `cmd_arg_i` in 32: command argument.
- `cmd_crc_i` in 7: externally supplied CRC7. Used only when the CRC macro is not defined.
- `cmd_o` out 1: serial CMD line data.
- `cmd_oe_o` out 1: CMD pad output enable.
- `busy_o` out 1: frame or gap in progress.
- `done_o` out 1: single-cycle pulse when the end bit completes.

## Operation

- **Frame layout:**
  - bit47 = 0 (start bit)
  - bit46 = 1 (transmission bit)
  - bits45:40 = index
  - bits39:8 = argument
  - bits7:1 = CRC7
  - bit0 = 1 (end bit)
  - The frame is sent MSb (bit47) first.
- **CRC7:** polynomial x^7+x^3+1, initial value 0, computed over frame bits 47..8. It is updated serially as each header bit is shifted out.
- **States:** IDLE, HEADER (40 bits), CRC (7 bits), END (1 bit), GAP.
  - IDLE: `cmd_ready_o`=1. A handshake (`cmd_valid_i` & `cmd_ready_o` on a `clk_i` edge) latches {0,1,index,arg} into a 40-bit shift register, clears the CRC and bit counter, and moves to HEADER. The handshake is independent of `clk_en_i`.
  - HEADER: each `clk_en_i` edge shifts one bit out and into the CRC. After the 40th strobe, move to CRC.
  - CRC: each `clk_en_i` edge shifts out one CRC bit, MSb first. After 7 strobes, move to END.
  - END: `cmd_o`=1. On a `clk_en_i` edge, pulse `done_o`. If `GapStrobes`=0, go to IDLE; otherwise go to GAP.
  - GAP: count `GapStrobes` `clk_en_i` strobes, then go to IDLE.
- **Output enable:** `cmd_oe_o`=1 in HEADER, CRC and END; 0 otherwise. Whenever `cmd_oe_o`=0, `cmd_o`=1.
- `busy_o` = (state != IDLE). `cmd_ready_o` = (state == IDLE).
- Inputs are sampled only at the handshake. Later changes to them have no effect on the frame in progress.
- `cmd_valid_i` while busy is ignored and not queued. The requester must hold `cmd_valid_i` until ready.

## Timing

- **Reset values:**
  - `cmd_o`=1
  - `cmd_oe_o`=0
  - `cmd_ready_o`=1
  - `busy_o`=0
  - `done_o`=0
  - State IDLE; counters, shift register and CRC all zero.
- **Reset mid-frame:** asynchronous assertion forces the reset values immediately, with no end bit. Operation resumes from IDLE after deassertion.
- **Start of frame:** `cmd_o` and `cmd_oe_o` are registered. The start bit is visible in the `clk_i` cycle after the handshake.
- **Bit hold:** each bit is held until the next `clk_i` edge with `clk_en_i`=1. A strobe in the handshake cycle does not advance the frame.
- **End of frame:** exactly 48 strobes after the handshake, `cmd_oe_o` falls and `done_o`=1 for one `clk_i` cycle.
- **Back-to-back commands:**
  - With `GapStrobes`=0, `cmd_ready_o` is high in the `done_o` cycle, so a new handshake is possible there.
  - Otherwise, `cmd_ready_o` rises after the `GapStrobes`-th strobe in GAP.
- **`clk_en_i` stuck at 0:** the frame freezes with the current bit held. There is no timeout.

## Configuration

- Macro: `SDHCI_CMD_TX_CRC7_EN`.
- **Defined:** CRC7 is generated internally as above. `cmd_crc_i` is ignored.
- **Undefined:** no CRC logic is built. `cmd_crc_i` is latched at the handshake and sent verbatim in bits7:1.

## Test plan

- **CMD0:** CMD0, arg 0x00000000, `clk_en_i` every 4th cycle, macro defined -> serial stream 0x400000000095. `cmd_oe_o` high for exactly 48 strobes. `done_o` one pulse.
- **CMD8:** CMD8, arg 0x000001AA -> stream 0x48000001AA87. CMD17, arg 0 -> stream 0x510000000055.
- **Back-to-back with gap:** `GapStrobes`=8, `cmd_valid_i` held high continuously -> second start bit appears exactly 8 strobes after the first `done_o`. With `GapStrobes`=0 -> start bit immediately follows the end bit.
- **Input stability:** `clk_en_i` low for 20 cycles mid-HEADER, and `cmd_index_i`/`cmd_arg_i` changed while busy -> bit held, frame unchanged, `cmd_ready_o`=0 throughout.
- **Reset mid-frame:** `rst_ni` asserted at bit 20 -> same cycle `cmd_oe_o`=0, `cmd_o`=1, `cmd_ready_o`=1, no `done_o`. The next command is sent correctly.
- **Macro undefined:** CMD0 with `cmd_crc_i`=0x55 -> bits7:1 = 1010101, end bit 1.
